// File: rtl/hssl_cfg_pkg.sv
// Shared types and defaults for the HSSL config packet receiver.
// Build option: CFG_REPLY_EN adds the write-acknowledge reply path.
`ifndef REG_ADR_BITS
`define REG_ADR_BITS 8
`endif

package hssl_cfg_pkg;

    localparam int REG_ADR_BITS = `REG_ADR_BITS;

    localparam logic [31:0] CFG_KEY_DEF = 32'hffff_fe00;
    localparam logic [31:0] CFG_MSK_DEF = 32'hffff_ff00;

    typedef struct packed {
        logic [31:0] key;
        logic [31:0] data;
        logic        pld;
    } hssl_pkt_t;

    // True when the masked key selects the configuration space.
    function automatic logic cfg_match(
        input logic [31:0] key,
        input logic [31:0] ref_key,
        input logic [31:0] msk
    );
        return (key & msk) == (ref_key & msk);
    endfunction

endpackage

// File: rtl/hssl_cfg_pkt_rx_slice.sv
// One-deep valid/ready register stage for hssl_pkt_t.
// Reloads in the same cycle it drains, so a full-rate stream has no bubbles.
module pkt_reg_slice
    import hssl_cfg_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  hssl_pkt_t in_pkt,
    input  logic      in_vld,
    output logic      in_rdy,
    output hssl_pkt_t out_pkt,
    output logic      out_vld,
    input  logic      out_rdy
);

    assign in_rdy = !out_vld || out_rdy;

    // Capture on an accepted input; otherwise empty once the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pkt <= '0;
            out_vld <= 1'b0;
        end else if (in_vld && in_rdy) begin
            out_pkt <= in_pkt;
            out_vld <= 1'b1;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/hssl_cfg_pkt_rx.sv
// HSSL receive splitter: config packets become register writes, others pass on.
// Build option: CFG_REPLY_EN returns an ack packet for each config write.
module hssl_cfg_pkt_rx
    import hssl_cfg_pkg::*;
#(
    parameter logic [31:0] CFG_KEY = CFG_KEY_DEF,
    parameter logic [31:0] CFG_MSK = CFG_MSK_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pkt_key_in,
    input  logic [31:0]              pkt_data_in,
    input  logic                     pkt_pld_in,
    input  logic                     pkt_vld_in,
    output logic                     pkt_rdy_out,
    output logic [31:0]              out_key_out,
    output logic [31:0]              out_data_out,
    output logic                     out_pld_out,
    output logic                     out_vld_out,
    input  logic                     out_rdy_in,
    output logic [REG_ADR_BITS-1:0]  prx_addr_out,
    output logic [31:0]              prx_wdata_out,
    output logic                     prx_en_out,
    output logic                     cfg_err_out
`ifdef CFG_REPLY_EN
    ,
    input  logic [31:0]              reply_key_in,
    output logic [31:0]              rpl_key_out,
    output logic [31:0]              rpl_data_out,
    output logic                     rpl_vld_out,
    input  logic                     rpl_rdy_in
`endif
);

    hssl_pkt_t in_pkt;
    hssl_pkt_t dat_pkt;
    logic      is_cfg;
    logic      acc;
    logic      dat_rdy;
    logic      rpl_ok;
    logic      wr_go;
    logic      err_go;

    assign in_pkt = '{key: pkt_key_in, data: pkt_data_in, pld: pkt_pld_in};
    assign is_cfg = cfg_match(pkt_key_in, CFG_KEY, CFG_MSK);

    // Ready never looks at the incoming key, only at downstream space.
    assign pkt_rdy_out = dat_rdy && rpl_ok;
    assign acc         = pkt_vld_in && pkt_rdy_out;
    assign wr_go       = acc && is_cfg && pkt_pld_in;
    assign err_go      = acc && is_cfg && !pkt_pld_in;

    pkt_reg_slice u_out_slice (
        .clk     (clk),
        .reset   (reset),
        .in_pkt  (in_pkt),
        .in_vld  (acc && !is_cfg),
        .in_rdy  (dat_rdy),
        .out_pkt (dat_pkt),
        .out_vld (out_vld_out),
        .out_rdy (out_rdy_in)
    );

    assign out_key_out  = dat_pkt.key;
    assign out_data_out = dat_pkt.data;
    assign out_pld_out  = dat_pkt.pld;

    // Single-cycle strobes; address and data persist between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prx_en_out    <= 1'b0;
            prx_addr_out  <= '0;
            prx_wdata_out <= '0;
            cfg_err_out   <= 1'b0;
        end else begin
            prx_en_out  <= wr_go;
            cfg_err_out <= err_go;
            if (wr_go) begin
                prx_addr_out  <= pkt_key_in[REG_ADR_BITS-1:0];
                prx_wdata_out <= pkt_data_in;
            end
        end
    end

`ifdef CFG_REPLY_EN
    hssl_pkt_t rpl_in;
    hssl_pkt_t rpl_pkt;
    logic      unused_rpl_pld;

    assign rpl_in = '{
        key:  reply_key_in,
        data: {{(32-REG_ADR_BITS){1'b0}}, pkt_key_in[REG_ADR_BITS-1:0]},
        pld:  1'b1
    };

    pkt_reg_slice u_rpl_slice (
        .clk     (clk),
        .reset   (reset),
        .in_pkt  (rpl_in),
        .in_vld  (wr_go),
        .in_rdy  (rpl_ok),
        .out_pkt (rpl_pkt),
        .out_vld (rpl_vld_out),
        .out_rdy (rpl_rdy_in)
    );

    assign rpl_key_out    = rpl_pkt.key;
    assign rpl_data_out   = rpl_pkt.data;
    assign unused_rpl_pld = rpl_pkt.pld;
`else
    assign rpl_ok = 1'b1;
`endif

endmodule

// File: tb/tb_hssl_cfg_pkt_rx.sv
// Randomized and directed bench for hssl_cfg_pkt_rx with a queue-based model.
// Build option: CFG_REPLY_EN also exercises the ack reply path.
`ifndef REG_ADR_BITS
`define REG_ADR_BITS 8
`endif

module tb_hssl_cfg_pkt_rx;

    localparam int AW = `REG_ADR_BITS;
    localparam logic [31:0] KEY = 32'hffff_fe00;
    localparam logic [31:0] MSK = 32'hffff_ff00;

    typedef struct {
        logic [31:0] key;
        logic [31:0] data;
        logic        pld;
    } mpkt_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   pkt_key_in = '0;
    logic [31:0]   pkt_data_in = '0;
    logic          pkt_pld_in = 1'b0;
    logic          pkt_vld_in = 1'b0;
    logic          pkt_rdy_out;
    logic [31:0]   out_key_out;
    logic [31:0]   out_data_out;
    logic          out_pld_out;
    logic          out_vld_out;
    logic          out_rdy_in = 1'b1;
    logic [AW-1:0] prx_addr_out;
    logic [31:0]   prx_wdata_out;
    logic          prx_en_out;
    logic          cfg_err_out;
`ifdef CFG_REPLY_EN
    logic [31:0]   reply_key_in = '0;
    logic [31:0]   rpl_key_out;
    logic [31:0]   rpl_data_out;
    logic          rpl_vld_out;
    logic          rpl_rdy_in = 1'b1;
    mpkt_t         rq[$];
`endif

    int checks = 0;
    int failures = 0;

    mpkt_t         q[$];
    logic          exp_en = 1'b0;
    logic          exp_err = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   exp_wdata = '0;

    hssl_cfg_pkt_rx dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_key_in    (pkt_key_in),
        .pkt_data_in   (pkt_data_in),
        .pkt_pld_in    (pkt_pld_in),
        .pkt_vld_in    (pkt_vld_in),
        .pkt_rdy_out   (pkt_rdy_out),
        .out_key_out   (out_key_out),
        .out_data_out  (out_data_out),
        .out_pld_out   (out_pld_out),
        .out_vld_out   (out_vld_out),
        .out_rdy_in    (out_rdy_in),
        .prx_addr_out  (prx_addr_out),
        .prx_wdata_out (prx_wdata_out),
        .prx_en_out    (prx_en_out),
        .cfg_err_out   (cfg_err_out)
`ifdef CFG_REPLY_EN
        ,
        .reply_key_in  (reply_key_in),
        .rpl_key_out   (rpl_key_out),
        .rpl_data_out  (rpl_data_out),
        .rpl_vld_out   (rpl_vld_out),
        .rpl_rdy_in    (rpl_rdy_in)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic step(input logic v, input logic [31:0] k,
                        input logic [31:0] d, input logic p,
                        input logic ordy, output logic acc);
        logic cfg;
        logic erdy;
        mpkt_t np;
        @(posedge clk);
        #1;
        pkt_vld_in  = v;
        pkt_key_in  = k;
        pkt_data_in = d;
        pkt_pld_in  = p;
        out_rdy_in  = ordy;
        @(negedge clk);
        cfg  = ((k & MSK) == (KEY & MSK));
        erdy = (q.size() == 0) || ordy;
`ifdef CFG_REPLY_EN
        erdy = erdy && ((rq.size() == 0) || rpl_rdy_in);
        chk("rpl_vld", rpl_vld_out, rq.size() != 0);
        if (rq.size() != 0) begin
            chk("rpl_key", rpl_key_out, rq[0].key);
            chk("rpl_data", rpl_data_out, rq[0].data);
        end
`endif
        chk("pkt_rdy", pkt_rdy_out, erdy);
        chk("out_vld", out_vld_out, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_key", out_key_out, q[0].key);
            chk("out_data", out_data_out, q[0].data);
            chk("out_pld", out_pld_out, q[0].pld);
        end
        chk("prx_en", prx_en_out, exp_en);
        chk("prx_addr", prx_addr_out, exp_addr);
        chk("prx_wdata", prx_wdata_out, exp_wdata);
        chk("cfg_err", cfg_err_out, exp_err);
        acc = v && erdy;
        if (q.size() != 0 && ordy) void'(q.pop_front());
`ifdef CFG_REPLY_EN
        if (rq.size() != 0 && rpl_rdy_in) void'(rq.pop_front());
`endif
        exp_en  = 1'b0;
        exp_err = 1'b0;
        if (acc) begin
            if (!cfg) begin
                np = '{key: k, data: d, pld: p};
                q.push_back(np);
            end else if (p) begin
                exp_en    = 1'b1;
                exp_addr  = k[AW-1:0];
                exp_wdata = d;
`ifdef CFG_REPLY_EN
                np = '{key: reply_key_in, data: 32'(k[AW-1:0]), pld: 1'b1};
                rq.push_back(np);
`endif
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        pkt_vld_in = 1'b0;
        #2;
        chk("rst_out_vld", out_vld_out, 1'b0);
        chk("rst_prx_en", prx_en_out, 1'b0);
        chk("rst_cfg_err", cfg_err_out, 1'b0);
        chk("rst_pkt_rdy", pkt_rdy_out, 1'b1);
        chk("rst_out_key", out_key_out, 32'h0);
        chk("rst_prx_addr", prx_addr_out, '0);
`ifdef CFG_REPLY_EN
        chk("rst_rpl_vld", rpl_vld_out, 1'b0);
        rq.delete();
`endif
        q.delete();
        exp_en    = 1'b0;
        exp_err   = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic [31:0] k;
        logic [31:0] d;
        logic p;
        logic v;
        logic [31:0] rk;
        int n;
        apply_reset();

        // Full-rate data stream with no backpressure.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 32'(i), $urandom, 1'b1, 1'b1, a);
            chk("t1_acc", a, 1'b1);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, a);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);

        // Config write, then payload-less config.
        step(1'b1, 32'hffff_fe12, 32'hdead_beef, 1'b1, 1'b1, a);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);
        chk("t2_addr", prx_addr_out, 8'h12);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);
        step(1'b1, 32'hffff_fe05, 32'h1234_5678, 1'b0, 1'b1, a);
        chk("t3_acc", a, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);

        // Backpressure with the slice full, then release.
        step(1'b1, 32'h0000_0a00, 32'haaaa_0001, 1'b1, 1'b0, a);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0000_0b00, 32'hbbbb_0002, 1'b0, 1'b0, a);
            chk("t4_stall", a, 1'b0);
        end
        step(1'b1, 32'h0000_0b00, 32'hbbbb_0002, 1'b0, 1'b1, a);
        chk("t4_resume", a, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);

        // Interleaved data / config / data at full rate.
        step(1'b1, 32'h0000_0c01, 32'hc0c0_0001, 1'b1, 1'b1, a);
        chk("t5_acc0", a, 1'b1);
        step(1'b1, 32'hffff_fe33, 32'h3333_3333, 1'b1, 1'b1, a);
        chk("t5_acc1", a, 1'b1);
        step(1'b1, 32'h0000_0c02, 32'hc0c0_0002, 1'b1, 1'b1, a);
        chk("t5_acc2", a, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);
        step(1'b0, '0, '0, 1'b0, 1'b1, a);

`ifdef CFG_REPLY_EN
        // Reply register fills and stalls the next config; reset mid-stall.
        rpl_rdy_in   = 1'b0;
        reply_key_in = 32'hffff_fd00;
        step(1'b1, 32'hffff_fe21, 32'h0000_0021, 1'b1, 1'b1, a);
        chk("t6_acc", a, 1'b1);
        reply_key_in = 32'h0bad_0bad;
        step(1'b1, 32'h0000_0d00, 32'hd0d0_0001, 1'b1, 1'b0, a);
        chk("t6_rkey", rpl_key_out, 32'hffff_fd00);
        chk("t6_rdata", rpl_data_out, 32'h21);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hffff_fe22, 32'h0000_0022, 1'b1, 1'b1, a);
            chk("t6_stall", a, 1'b0);
        end
        apply_reset();
        chk("t6_rst_out_vld", out_vld_out, 1'b0);
        rpl_rdy_in = 1'b1;
`endif

        // Randomized traffic with held-until-accepted valid semantics.
        v = 1'b0;
        k = '0;
        d = '0;
        p = 1'b0;
        a = 1'b1;
        for (n = 0; n < 1500; n++) begin
            if (!v || a) begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0)
                    k = KEY | 32'($urandom_range(0, 255));
                else
                    k = $urandom;
                d = $urandom;
                p = ($urandom_range(0, 4) != 0);
            end
`ifdef CFG_REPLY_EN
            rpl_rdy_in = ($urandom_range(0, 2) != 0);
            rk = $urandom;
            reply_key_in = rk;
`else
            rk = '0;
`endif
            step(v, k, d, p, ($urandom_range(0, 3) != 0), a);
            if (n == 700) begin
                apply_reset();
                v = 1'b0;
            end
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
